// File: rtl/debug_trace_collector.sv
// Trace-packet receiver: frames TPE bursts into HDR/DATA/LAST/TRUNC records,
// buffers them in a show-ahead FIFO and drains them over a valid/ready port.
module debug_trace_collector #(
    parameter int DEPTH_LOG2 = 4,
    parameter int TS_W       = 24
) (
    input  logic                  clk,
    input  logic                  MRST,
    input  logic                  en,
    input  logic                  TPE,
    input  logic [31:0]           TP,
    input  logic [7:0]            EV,
    output logic                  m_valid,
    output logic [1:0]            m_type,
    output logic [31:0]           m_data,
    input  logic                  m_ready,
    input  logic                  clr_ovf,
    output logic                  ovf,
    output logic [7:0]            drop_cnt,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] TWO   = (DEPTH_LOG2 + 1)'(2);
    localparam logic [DEPTH_LOG2:0] THREE = (DEPTH_LOG2 + 1)'(3);

    typedef enum logic [1:0] {IDLE, BURST, DISCARD} state_t;
    typedef enum logic [1:0] {T_HDR = 2'b00, T_DATA = 2'b01, T_LAST = 2'b10, T_TRUNC = 2'b11} rec_t;

    state_t                 state;
    logic [TS_W-1:0]        ts;
    logic [31:0]            hold;
    logic [33:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wptr;
    logic [DEPTH_LOG2-1:0]  rptr;
    logic [DEPTH_LOG2:0]    free;
    logic [33:0]            head;
    logic [33:0]            push_word;
    logic                   push;
    logic                   pop;
    logic                   drop_ev;
    logic                   trunc_ev;

    // free deliberately ignores a same-cycle pop
    assign free    = FULL - level;
    assign m_valid = (level != '0);
    assign pop     = m_valid & m_ready;
    assign head    = mem[rptr];
    assign m_type  = m_valid ? head[33:32] : '0;
    assign m_data  = m_valid ? head[31:0]  : '0;

    always_comb begin
        push      = 1'b0;
        push_word = '0;
        drop_ev   = 1'b0;
        trunc_ev  = 1'b0;
        case (state)
            IDLE: begin
                if (TPE && en) begin
                    if (free >= THREE) begin
                        push      = 1'b1;
                        push_word = {T_HDR, ts, EV};
                    end else begin
                        drop_ev = 1'b1;
                    end
                end
            end
            BURST: begin
                push = 1'b1;
                if (!TPE)
                    push_word = {T_LAST, hold};
                else if (free >= TWO)
                    push_word = {T_DATA, hold};
                else begin
                    push_word = {T_TRUNC, hold};
                    trunc_ev  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            state    <= IDLE;
            ts       <= '0;
            hold     <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ts <= ts + 1'b1;
            case (state)
                IDLE: begin
                    if (TPE) begin
                        if (!en || drop_ev) begin
                            state <= DISCARD;
                        end else begin
                            state <= BURST;
                            hold  <= TP;
                        end
                    end
                end
                BURST: begin
                    if (!TPE)
                        state <= IDLE;
                    else if (trunc_ev)
                        state <= DISCARD;
                    else
                        hold <= TP;
                end
                DISCARD: if (!TPE) state <= IDLE;
                default: state <= IDLE;
            endcase
            // a coincident event overrides clr_ovf
            if (drop_ev || trunc_ev)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
            if (drop_ev)
                drop_cnt <= clr_ovf ? 8'd1 : ((drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 1'b1);
            else if (clr_ovf)
                drop_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= push_word;
    end

    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

endmodule

// File: tb/tb_debug_trace_collector.sv
// Directed bench for debug_trace_collector: a 16-entry and a 4-entry instance share stimulus.
module tb_debug_trace_collector;

    logic        clk = 1'b0;
    logic        MRST, en, TPE, m_ready, clr_ovf;
    logic [31:0] TP;
    logic [7:0]  EV;

    logic        mv, ov, mv2, ov2;
    logic [1:0]  mt, mt2;
    logic [31:0] md, md2;
    logic [7:0]  dc, dc2;
    logic [4:0]  lv;
    logic [2:0]  lv2;

    int vec = 0;
    int err = 0;
    logic [23:0] tb_ts;

    always #5 clk = ~clk;

    always @(posedge clk or negedge MRST)
        if (!MRST) tb_ts <= '0;
        else       tb_ts <= tb_ts + 24'd1;

    debug_trace_collector #(.DEPTH_LOG2(4), .TS_W(24)) dut (
        .clk(clk), .MRST(MRST), .en(en), .TPE(TPE), .TP(TP), .EV(EV),
        .m_valid(mv), .m_type(mt), .m_data(md), .m_ready(m_ready),
        .clr_ovf(clr_ovf), .ovf(ov), .drop_cnt(dc), .level(lv)
    );

    debug_trace_collector #(.DEPTH_LOG2(2), .TS_W(24)) dut2 (
        .clk(clk), .MRST(MRST), .en(en), .TPE(TPE), .TP(TP), .EV(EV),
        .m_valid(mv2), .m_type(mt2), .m_data(md2), .m_ready(m_ready),
        .clr_ovf(clr_ovf), .ovf(ov2), .drop_cnt(dc2), .level(lv2)
    );

    task automatic do_reset();
        @(negedge clk);
        MRST = 1'b0; TPE = 1'b0; en = 1'b1; m_ready = 1'b1; clr_ovf = 1'b0;
        TP = '0; EV = '0;
        repeat (2) @(negedge clk);
        MRST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if ({mv, mt, md, ov, dc, lv} !== 49'd0) begin
            err++; $display("FAIL reset_big: got %h exp 0", {mv, mt, md, ov, dc, lv});
        end
        vec++;
        if ({mv2, mt2, md2, ov2, dc2, lv2} !== 47'd0) begin
            err++; $display("FAIL reset_small: got %h exp 0", {mv2, mt2, md2, ov2, dc2, lv2});
        end
    endtask

    task automatic test_basic();
        do_reset();
        repeat (7) @(negedge clk);
        TPE = 1'b1; TP = 32'h11; EV = 8'h05;
        @(negedge clk);
        vec++;
        if ({mv, mt, md} !== {1'b1, 2'b00, 32'h0000_0705}) begin
            err++; $display("FAIL basic_hdr: got %h exp %h", {mv, mt, md}, {1'b1, 2'b00, 32'h0000_0705});
        end
        TP = 32'h22;
        @(negedge clk);
        vec++;
        if ({mv, mt, md} !== {1'b1, 2'b01, 32'h11}) begin
            err++; $display("FAIL basic_data: got %h exp %h", {mv, mt, md}, {1'b1, 2'b01, 32'h11});
        end
        TPE = 1'b0;
        @(negedge clk);
        vec++;
        if ({mv, mt, md} !== {1'b1, 2'b10, 32'h22}) begin
            err++; $display("FAIL basic_last: got %h exp %h", {mv, mt, md}, {1'b1, 2'b10, 32'h22});
        end
        @(negedge clk);
        vec++;
        if ({mv, ov, lv} !== 7'd0) begin
            err++; $display("FAIL basic_empty: got %h exp 0", {mv, ov, lv});
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] exp_q [4];
        do_reset();
        m_ready = 1'b0;
        @(negedge clk);
        exp_q[0] = {1'b1, 2'b00, tb_ts, 8'h3C};
        TPE = 1'b1; TP = 32'hA; EV = 8'h3C;
        @(negedge clk);
        TPE = 1'b0; TP = 32'h0;
        @(negedge clk);
        exp_q[2] = {1'b1, 2'b00, tb_ts, 8'hC3};
        TPE = 1'b1; TP = 32'hB; EV = 8'hC3;
        @(negedge clk);
        TPE = 1'b0;
        @(negedge clk);
        exp_q[1] = {1'b1, 2'b10, 32'hA};
        exp_q[3] = {1'b1, 2'b10, 32'hB};
        vec++;
        if (lv !== 5'd4) begin
            err++; $display("FAIL b2b_level: got %0d exp 4", lv);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vec++;
            if ({mv, mt, md} !== exp_q[i]) begin
                err++; $display("FAIL b2b_entry%0d: got %h exp %h", i, {mv, mt, md}, exp_q[i]);
            end
            @(negedge clk);
        end
        vec++;
        if (mv !== 1'b0) begin
            err++; $display("FAIL b2b_drained: got %b exp 0", mv);
        end
    endtask

    task automatic test_truncate_drop();
        logic [34:0] exp_q [4];
        do_reset();
        m_ready = 1'b0;
        @(negedge clk);
        exp_q[0] = {1'b1, 2'b00, tb_ts, 8'h77};
        for (int i = 1; i <= 6; i++) begin
            TPE = 1'b1; TP = 32'hD0 + 32'(i); EV = 8'h77;
            @(negedge clk);
        end
        TPE = 1'b0;
        @(negedge clk);
        exp_q[1] = {1'b1, 2'b01, 32'hD1};
        exp_q[2] = {1'b1, 2'b01, 32'hD2};
        exp_q[3] = {1'b1, 2'b11, 32'hD3};
        vec++;
        if ({lv2, ov2, dc2} !== {3'd4, 1'b1, 8'd0}) begin
            err++; $display("FAIL trunc_status: got %h exp %h", {lv2, ov2, dc2}, {3'd4, 1'b1, 8'd0});
        end
        // full FIFO: a new 1-word burst is dropped
        TPE = 1'b1; TP = 32'hE; EV = 8'h01;
        @(negedge clk);
        TPE = 1'b0;
        @(negedge clk);
        vec++;
        if ({lv2, ov2, dc2} !== {3'd4, 1'b1, 8'd1}) begin
            err++; $display("FAIL drop_status: got %h exp %h", {lv2, ov2, dc2}, {3'd4, 1'b1, 8'd1});
        end
        // drop coinciding with clr_ovf: event wins, count restarts at 1
        TPE = 1'b1; clr_ovf = 1'b1;
        @(negedge clk);
        TPE = 1'b0; clr_ovf = 1'b0;
        @(negedge clk);
        vec++;
        if ({ov2, dc2} !== {1'b1, 8'd1}) begin
            err++; $display("FAIL clr_vs_drop: got %h exp %h", {ov2, dc2}, {1'b1, 8'd1});
        end
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        vec++;
        if ({ov2, dc2} !== 9'd0) begin
            err++; $display("FAIL clr_ovf: got %h exp 0", {ov2, dc2});
        end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vec++;
            if ({mv2, mt2, md2} !== exp_q[i]) begin
                err++; $display("FAIL trunc_entry%0d: got %h exp %h", i, {mv2, mt2, md2}, exp_q[i]);
            end
            @(negedge clk);
        end
        vec++;
        if ({mv2, lv2} !== 4'd0) begin
            err++; $display("FAIL trunc_drained: got %h exp 0", {mv2, lv2});
        end
    endtask

    task automatic test_enable();
        logic [34:0] exp_hdr;
        do_reset();
        m_ready = 1'b0; en = 1'b0;
        TPE = 1'b1; TP = 32'h1;
        repeat (2) @(negedge clk);
        en = 1'b1; TP = 32'h2;
        repeat (2) @(negedge clk);
        vec++;
        if ({lv, ov, dc} !== 14'd0) begin
            err++; $display("FAIL en_blocked: got %h exp 0", {lv, ov, dc});
        end
        TPE = 1'b0;
        @(negedge clk);
        exp_hdr = {1'b1, 2'b00, tb_ts, 8'h99};
        TPE = 1'b1; TP = 32'h55; EV = 8'h99;
        @(negedge clk);
        TPE = 1'b0;
        @(negedge clk);
        vec++;
        if ({lv, mv, mt, md} !== {5'd2, exp_hdr}) begin
            err++; $display("FAIL en_reopen: got %h exp %h", {lv, mv, mt, md}, {5'd2, exp_hdr});
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [34:0] exp_hdr;
        do_reset();
        m_ready = 1'b0;
        TPE = 1'b1; TP = 32'h1234; EV = 8'h10;
        repeat (3) @(negedge clk);
        vec++;
        if (lv !== 5'd3) begin
            err++; $display("FAIL mid_level: got %0d exp 3", lv);
        end
        MRST = 1'b0; TPE = 1'b0;
        #1;
        vec++;
        if ({mv, mt, md, lv} !== 40'd0) begin
            err++; $display("FAIL mid_async: got %h exp 0", {mv, mt, md, lv});
        end
        @(negedge clk);
        MRST = 1'b1;
        exp_hdr = {1'b1, 2'b00, tb_ts, 8'h42};
        TPE = 1'b1; TP = 32'h66; EV = 8'h42;
        @(negedge clk);
        vec++;
        if ({lv, mv, mt, md} !== {5'd1, exp_hdr}) begin
            err++; $display("FAIL mid_fresh_hdr: got %h exp %h", {lv, mv, mt, md}, {5'd1, exp_hdr});
        end
        TPE = 1'b0;
        @(negedge clk);
        vec++;
        if (lv !== 5'd2) begin
            err++; $display("FAIL mid_fresh_level: got %0d exp 2", lv);
        end
    endtask

    initial begin
        MRST = 1'b0; en = 1'b1; TPE = 1'b0; TP = '0; EV = '0;
        m_ready = 1'b1; clr_ovf = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_truncate_drop();
        test_enable();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
